// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: debounced press detection with lockout, two-operand BCD
// entry FSM, valid/ready hand-off and a registered display bus.
module keypad_operand_entry #(
  parameter int unsigned DIGITS         = 3,
  parameter int unsigned LOCKOUT_CYCLES = 270000
) (
  input  logic                               clk,
  input  logic                               n_reset,
  input  logic [3:0]                         key_code,
  input  logic                               key_down,
  output logic [4*DIGITS-1:0]                operand_a,
  output logic [4*DIGITS-1:0]                operand_b,
  output logic                               ops_valid,
  input  logic                               ops_ready,
  output logic [4*DIGITS-1:0]                display_bcd,
  output logic [$clog2(DIGITS+1)-1:0]        digit_count,
  output logic [1:0]                         entry_state
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned CW = $clog2(DIGITS + 1);
  localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_STAR = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    DONE    = 2'd2
  } state_t;

  logic [2:0]    sync_q;
  logic [1:0]    fill_q;
  logic          armed_q;
  logic [LW-1:0] lock_q;
  logic          press;
  logic          accept;

  state_t        state_q, state_n;
  logic [W-1:0]  opa_q, opa_n, opb_q, opb_n, disp_q, disp_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          valid_q, valid_n;
  logic          is_digit, can_append;
  logic [W-1:0]  app_a, app_b;

  // Presses are only armed once the synchroniser has seen key_down low after
  // reset, so a key held through reset release never counts as a press.
  assign press  = sync_q[1] & ~sync_q[2] & armed_q;
  assign accept = press & (lock_q == '0);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      lock_q  <= '0;
    end else begin
      sync_q  <= {sync_q[1:0], key_down};
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync_q[1]);
      if (accept)
        lock_q <= LW'(LOCKOUT_CYCLES);
      else if (lock_q != '0)
        lock_q <= lock_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ENTER_A;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_n;
      opa_q   <= opa_n;
      opb_q   <= opb_n;
      cnt_q   <= cnt_n;
      valid_q <= valid_n;
      disp_q  <= disp_n;
    end
  end

  // Entry FSM; handshake in DONE yields only to a simultaneous clear key.
  always_comb begin
    state_n    = state_q;
    opa_n      = opa_q;
    opb_n      = opb_q;
    cnt_n      = cnt_q;
    is_digit   = (key_code <= 4'd9);
    can_append = (cnt_q < CW'(DIGITS));
    app_a      = (cnt_q == '0) ? W'(key_code) : W'({opa_q, key_code});
    app_b      = (cnt_q == '0) ? W'(key_code) : W'({opb_q, key_code});

    unique case (state_q)
      ENTER_A: begin
        if (accept) begin
          if (is_digit) begin
            if (can_append) begin
              opa_n = app_a;
              cnt_n = cnt_q + CW'(1);
            end
          end else if (key_code == KEY_A) begin
            if (cnt_q != '0) begin
              state_n = ENTER_B;
              cnt_n   = '0;
              opb_n   = '0;
            end
          end else if (key_code == KEY_STAR) begin
            opa_n = '0;
            opb_n = '0;
            cnt_n = '0;
          end
        end
      end
      ENTER_B: begin
        if (accept) begin
          if (is_digit) begin
            if (can_append) begin
              opb_n = app_b;
              cnt_n = cnt_q + CW'(1);
            end
          end else if (key_code == KEY_HASH) begin
            if (cnt_q != '0) state_n = DONE;
          end else if (key_code == KEY_STAR) begin
            state_n = ENTER_A;
            opa_n   = '0;
            opb_n   = '0;
            cnt_n   = '0;
          end
        end
      end
      DONE: begin
        if (accept && key_code == KEY_STAR) begin
          state_n = ENTER_A;
          opa_n   = '0;
          opb_n   = '0;
          cnt_n   = '0;
        end else if (ops_ready) begin
          state_n = ENTER_A;
          cnt_n   = '0;
        end
      end
      default: state_n = ENTER_A;
    endcase

    valid_n = (state_n == DONE);
    disp_n  = (state_n == ENTER_A) ? opa_n : opb_n;
  end

  assign operand_a   = opa_q;
  assign operand_b   = opb_q;
  assign ops_valid   = valid_q;
  assign display_bcd = disp_q;
  assign digit_count = cnt_q;
  assign entry_state = 2'(state_q);

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Sits directly downstream of the keypad scan/decoder stage.
- Consumes the held 4-bit key code plus a key-down level, detects each new press, and applies a lockout window.
- Assembles two multi-digit BCD operands under a small entry FSM.
- Hands the operand pair to the arithmetic/display stage with a valid/ready handshake, and drives a BCD display bus showing the operand being typed.

Parameters:
- DIGITS, 3: max BCD digits per operand (1..7).
- LOCKOUT_CYCLES, 270000: clk cycles after an accepted press during which new presses are ignored (10 ms at 27 MHz); must be ≥1.

Ports:
- clk, input, 1: system clock.
- n_reset, input, 1: asynchronous active-low reset.
- key_code, input, 4: decoded key from the upstream stage, held stable while key_down is high. Codes: 0-9 digits, A=4'hA, B=4'hB, C=4'hC, *=4'hD, #=4'hE, F=none.
- key_down, input, 1: high while any key is pressed; asynchronous to the FSM and synchronised internally.
- operand_a, output, 4*DIGITS: BCD operand A; least-significant digit in bits [3:0].
- operand_b, output, 4*DIGITS: BCD operand B; same layout as operand_a.
- ops_valid, output, 1: operand pair complete.
- ops_ready, input, 1: consumer accepts the pair.
- display_bcd, output, 4*DIGITS: operand currently shown.
- digit_count, output, $clog2(DIGITS+1): digits entered in the current operand.
- entry_state, output, 2: 0=ENTER_A, 1=ENTER_B, 2=DONE.

Behaviour:
- Reset (async assert, sync release):
  - operand_a=0, operand_b=0, ops_valid=0, digit_count=0, entry_state=ENTER_A.
  - Sync flops=0, lockout counter=0, display_bcd=0.
- Press detection:
  - key_down passes through a 2-flop synchroniser; a rising edge on the synchronised signal is a press.
  - A press is accepted only when the lockout counter is 0. key_code is sampled in the same cycle.
  - On accept the counter loads LOCKOUT_CYCLES, then decrements to 0, saturating at 0.
  - Presses during lockout are discarded, never queued.
- Latency: key_down high before edge 0 -> accept decided after edge 1 -> state/operand update at edge 2. One press yields exactly one action.
- Digit append (code 0-9, when digit_count < DIGITS):
  - digit_count==0: operand <= zero-extended digit.
  - Otherwise: operand <= {operand[4*DIGITS-5:0], digit}.
  - digit_count increments.
  - At digit_count==DIGITS, further digits are ignored (no wrap, no shift-out).
- ENTER_A:
  - Digit: appends to operand_a.
  - A: if digit_count>0 -> ENTER_B, digit_count=0, operand_b=0. If digit_count==0, ignored.
  - *: clears both operands and digit_count; state stays ENTER_A.
  - B, C, #, F: ignored.
- ENTER_B:
  - Digit: appends to operand_b.
  - #: if digit_count>0 -> DONE, ops_valid=1 at the same edge. If digit_count==0, ignored.
  - *: full clear -> ENTER_A.
  - A, B, C, F: ignored.
- DONE:
  - ops_valid stays high; operands are frozen.
  - ops_valid&ops_ready at a clk edge -> ENTER_A, ops_valid=0, digit_count=0. Operands keep their values until the next digit reloads them.
  - *: ops_valid=0, full clear -> ENTER_A, with no handshake.
  - All other keys ignored.
- Simultaneous handshake and accepted key in DONE:
  - * wins: full clear.
  - Any other key is dropped and the handshake completes.
- ops_ready while ops_valid=0 has no effect.
- display_bcd = operand_a in ENTER_A; operand_b in ENTER_B and DONE. Registered, updating on the same edge as the operands.
- Reset mid-entry or mid-lockout returns immediately to the reset values; a key held across reset release is not a press until key_down falls and rises again.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan (DIGITS=3, LOCKOUT_CYCLES=4):
- Press 1,2, A, 3,4, # with clean gaps -> operand_a=12'h012, operand_b=12'h034, ops_valid=1, entry_state=2. Each update lands 2 edges after key_down rises.
- Press 9,8,7,6 in ENTER_A -> operand_a=12'h987, digit_count=3; fourth digit ignored.
- In DONE hold ops_ready=0 for 10 cycles -> ops_valid stays 1, operands stable. Raise ops_ready -> next edge ops_valid=0, ENTER_A, digit_count=0. Next press 5 -> operand_a=12'h005.
- Toggle key_down high 1 cycle, low 1, high again within lockout -> exactly one digit appended, digit_count increments by 1 only.
- Press A or # with digit_count=0 -> no state change. Press * in ENTER_B (operand_b=12'h034) -> all zero, ENTER_A.
- Assert n_reset low asynchronously mid-lockout with key_down held high -> outputs zero at once. After release, key still held -> no press; release and re-press 7 -> operand_a=12'h007.
